// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Handles load-use hazard bubbles, branch flush and memory stall, and keeps a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       id_ctl,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [7:0]       ex_ctl,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [3:0]       ex_funct,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             hazard,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic bubble;

  // rs2 is compared for every format; a false stall is harmless, a missed one is not.
  always_comb begin
    hazard     = ex_ctl[4] & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    bubble     = flush | hazard;
    pc_write   = reset | (~mem_stall & (flush | ~hazard));
    ifid_write = reset | (~mem_stall & (flush | ~hazard));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctl      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_funct    <= '0;
      bubble_cnt  <= '0;
    end else if (!mem_stall) begin
      ex_ctl      <= bubble ? '0 : id_ctl;
      ex_rd       <= bubble ? '0 : id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
      ex_funct    <= id_funct;
      if (bubble && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX state is pushed to a queue at drive time
// and popped/compared after the clock edge; combinational enables are checked before the edge.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       id_ctl;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [3:0]       id_funct;
  logic             flush, mem_stall;
  logic [7:0]       ex_ctl;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [3:0]       ex_funct;
  logic             pc_write, ifid_write, hazard;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_ctl(id_ctl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_funct(id_funct), .flush(flush), .mem_stall(mem_stall),
    .ex_ctl(ex_ctl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_funct(ex_funct), .pc_write(pc_write),
    .ifid_write(ifid_write), .hazard(hazard), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       ctl;
    logic [4:0]       rs1, rs2, rd;
    logic [XLEN-1:0]  d1, d2, imm, pc;
    logic [3:0]       fn;
    logic [CNT_W-1:0] cnt;
    logic             dv;   // data fields meaningful (not a bubble)
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [31:0] imm,
                      input logic fl, input logic st, input logic rs);
    exp_t n, e;
    logic hz, pw;
    reset       = rs;
    flush       = fl;
    mem_stall   = st;
    id_ctl      = c;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_imm      = imm;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_pc       = $urandom;
    id_funct    = 4'($urandom_range(0, 15));
    #1;
    hz = m.ctl[4] && (m.rd != 5'd0) && ((m.rd == r1) || (m.rd == r2));
    pw = rs | (!st & (fl | !hz));
    if (known) chk("hazard", 32'(hazard), 32'(hz));
    chk("pc_write", 32'(pc_write), 32'(pw));
    chk("ifid_write", 32'(ifid_write), 32'(pw));
    if (rs) begin
      n = '0;
      n.dv = 1'b1;
    end else if (st) begin
      n = m;
    end else begin
      n.ctl = c;   n.rs1 = r1; n.rs2 = r2; n.rd = rd;
      n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = imm; n.pc = id_pc;
      n.fn = id_funct; n.cnt = m.cnt; n.dv = 1'b1;
      if (fl || hz) begin
        n.ctl = 8'h00;
        n.rd  = 5'd0;
        n.dv  = 1'b0;
        if (m.cnt != {CNT_W{1'b1}}) n.cnt = m.cnt + 1'b1;
      end
    end
    q.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ex_ctl", 32'(ex_ctl), 32'(e.ctl));
    chk("ex_rd", 32'(ex_rd), 32'(e.rd));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
    if (e.dv) begin
      chk("ex_rs1", 32'(ex_rs1), 32'(e.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(e.rs2));
      chk("ex_rs1_data", ex_rs1_data, e.d1);
      chk("ex_rs2_data", ex_rs2_data, e.d2);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_funct", 32'(ex_funct), 32'(e.fn));
    end
    if (rs) known = 1'b1;
  endtask

  function automatic logic [4:0] r5();
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    m = '0;
    // reset with random ID-side activity
    step(8'($urandom), r5(), r5(), r5(), $urandom, 1'b0, 1'b0, 1'b1);
    step(8'($urandom), r5(), r5(), r5(), $urandom, 1'b0, 1'b0, 1'b1);
    // pass-through
    step(8'h22, 5'd1, 5'd2, 5'd3, 32'h10, 1'b0, 1'b0, 1'b0);
    // load-use on rs1: one bubble, then the held instruction advances
    step(8'hF0, 5'd3, 5'd4, 5'd5, 32'h4, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    // load to x0 never stalls
    step(8'hF0, 5'd1, 5'd2, 5'd0, 32'h8, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd0, 5'd0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    // consumer two slots after the load: no stall
    step(8'hF0, 5'd1, 5'd2, 5'd8, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd1, 5'd2, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd8, 5'd8, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    // load-use through rs2
    step(8'hF0, 5'd0, 5'd0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h06, 5'd1, 5'd9, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h06, 5'd1, 5'd9, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0);
    // flush coincident with hazard: single bubble, enables stay high
    step(8'hF0, 5'd0, 5'd0, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd10, 5'd0, 5'd11, 32'h0, 1'b1, 1'b0, 1'b0);
    // stall beats flush and hazard, then the hazard resolves
    step(8'hF0, 5'd0, 5'd0, 5'd11, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd11, 5'd1, 5'd12, 32'h0, 1'b1, 1'b1, 1'b0);
    step(8'h22, 5'd11, 5'd1, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'h22, 5'd11, 5'd1, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0);
    // reset during a stall clears the pending load
    step(8'hF0, 5'd0, 5'd0, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0);
    step(8'($urandom), r5(), r5(), r5(), $urandom, 1'b0, 1'b1, 1'b1);
    step(8'h22, 5'd13, 5'd13, 5'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    // counter saturation
    for (int i = 0; i < 20; i++)
      step(8'($urandom), r5(), r5(), r5(), $urandom, 1'b1, 1'b0, 1'b0);
    // random mix
    for (int i = 0; i < 16; i++)
      step(8'($urandom), r5(), r5(), r5(), $urandom,
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
